// File: rtl/req_arbiter8.sv
// req_arbiter8: eight-requester arbiter with registered one-hot grants.
// A grant is held until its requester drops req or the hold watchdog
// revokes it. Fixed priority (index 7 highest) or round-robin, chosen
// per arbitration by rr_en. Every release/revoke is followed by one idle
// turnaround cycle before the next grant.
//
// Handshake: req[i] is a level request that the agent keeps high while it
// wants or uses the resource. gnt[i] rises exactly one clock after req is
// sampled in IDLE, stays high while req[i] stays high (other requests are
// ignored, no preemption), and falls on the edge where req[i] is sampled
// low or where the watchdog fires. timeout pulses for the one cycle after
// a forced revoke.
module req_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int HCW      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rr_en,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout,
    output logic       dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // With the watchdog disabled the counter simply parks at all-ones.
    localparam logic [HCW-1:0] CNT_TOP =
        (MAX_HOLD == 0) ? {HCW{1'b1}} : HCW'(MAX_HOLD);
    localparam bit TIMEOUT_ON = (MAX_HOLD != 0);

    state_t         state;
    logic [HCW-1:0] cnt;
    logic [2:0]     last_id;
    logic [2:0]     win;
    logic [2:0]     idx;

    assign dbg_state = state;

    // Winner selection: later loop iterations override earlier ones, so the
    // last match seen is the highest-priority requester.
    always_comb begin
        win = 3'd0;
        idx = 3'd0;
        if (rr_en) begin
            // Order last_id-1, last_id-2, ..., last_id: walk it backwards.
            for (int i = 8; i >= 1; i--) begin
                idx = last_id - 3'(i);
                if (req[idx]) win = idx;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (req[i]) win = 3'(i);
            end
        end
    end

    // Grant FSM with registered outputs, hold counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 8'h00;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            cnt       <= '0;
            last_id   <= 3'd0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt       <= 8'b1 << win;
                        gnt_id    <= win;
                        gnt_valid <= 1'b1;
                        last_id   <= win;
                        cnt       <= HCW'(1);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (!req[gnt_id]) begin
                        // Normal release wins over a coincident timeout.
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else if (TIMEOUT_ON && cnt == CNT_TOP) begin
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
                        cnt       <= '0;
                        timeout   <= 1'b1;
                        state     <= IDLE;
                    end else if (cnt != CNT_TOP) begin
                        cnt <= cnt + HCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_req_arbiter8.sv
// Directed-vector bench for req_arbiter8 with default parameters
// (MAX_HOLD=16, HCW=5).
module tb_req_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       rr_en;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;
    logic       dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    req_arbiter8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rr_en     (rr_en),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [2:0] id);
        logic [7:0] exp_g;
        exp_g = 8'b1 << id;
        check({tag, "_gnt"}, 32'(gnt), 32'(exp_g));
        check({tag, "_id"}, 32'(gnt_id), 32'(id));
        check({tag, "_valid"}, 32'(gnt_valid), 32'd1);
    endtask

    task automatic check_idle(input string tag, input logic exp_to);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_valid"}, 32'(gnt_valid), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] exp_id;
        rst_n = 1'b0;
        req   = 8'hFF;
        rr_en = 1'b0;

        // Reset holds everything low even with all requests high.
        tick();
        tick();
        check_idle("rst", 1'b0);
        check("rst_id", 32'(gnt_id), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // Release reset with no requests: stays idle.
        req   = 8'h00;
        rst_n = 1'b1;
        tick();
        tick();
        check_idle("idle", 1'b0);

        // Fixed priority: 5 beats 2, then 2 after a one-cycle gap.
        rr_en = 1'b0;
        req   = 8'b0010_0100;
        tick();
        check_grant("fp_first", 3'd5);
        check("fp_state", 32'(dbg_state), 32'd1);
        req = 8'b0000_0100;
        tick();
        check_idle("fp_gap", 1'b0);
        tick();
        check_grant("fp_second", 3'd2);
        req = 8'h00;
        tick();
        check_idle("fp_rel", 1'b0);
        tick();

        // Round-robin from reset: 7,6,...,0,7, each holding 2 cycles.
        do_reset();
        rr_en = 1'b1;
        req   = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_id = 3'(7 - k);
            tick();
            check_grant($sformatf("rr%0d_c1", k), exp_id);
            tick();
            check_grant($sformatf("rr%0d_c2", k), exp_id);
            req[exp_id] = 1'b0;
            tick();
            check_idle($sformatf("rr%0d_gap", k), 1'b0);
            req = 8'hFF;
        end
        req = 8'h00;
        tick();
        tick();

        // Watchdog: agent 3 held forever gets exactly 16 cycles.
        rr_en = 1'b0;
        req   = 8'h08;
        tick();
        check_grant("to_c1", 3'd3);
        for (int i = 2; i <= 16; i++) begin
            tick();
            check($sformatf("to_c%0d_valid", i), 32'(gnt_valid), 32'd1);
            check($sformatf("to_c%0d_timeout", i), 32'(timeout), 32'd0);
        end
        tick();
        check_idle("to_fire", 1'b1);
        check("to_fire_state", 32'(dbg_state), 32'd0);
        tick();
        check("to_pulse_end", 32'(timeout), 32'd0);
        check_grant("to_regrant", 3'd3);

        // Release exactly on the edge where the counter is at its limit.
        for (int i = 2; i <= 16; i++) begin
            tick();
            check($sformatf("rel_c%0d_valid", i), 32'(gnt_valid), 32'd1);
        end
        req = 8'h00;
        tick();
        check_idle("rel_edge", 1'b0);
        check("rel_edge_state", 32'(dbg_state), 32'd0);
        tick();
        check_idle("rel_after", 1'b0);

        // Asynchronous reset between edges kills the grant at once and
        // clears the round-robin pointer.
        rr_en = 1'b0;
        req   = 8'h80;
        tick();
        check_grant("ar_pre", 3'd7);
        #2 rst_n = 1'b0;
        #1;
        check_idle("ar_async", 1'b0);
        check("ar_state", 32'(dbg_state), 32'd0);
        #2 rst_n = 1'b1;
        rr_en = 1'b1;
        req   = 8'h81;
        tick();
        check_grant("ar_regrant", 3'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
